lp_tree_deserializer: RTL and testbench

LP_TREE_DESERIALIZER -- requirements
Module: lp_tree_deserializer

---
 rtl/lp_serdes_pkg.sv | 17 +
 rtl/lp_tree_deserializer_if.sv | 31 +++
 rtl/lp_sync_detect.sv | 36 +++
 rtl/lp_tree_deserializer.sv | 117 +++++++++++
 tb/tb_lp_tree_deserializer.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/lp_serdes_pkg.sv
// -----------------------------------------------------------------------------
// lp_serdes_pkg
//   Definitions shared by the lp_tree serializer/deserializer pair and their
//   benches: default word width, default alignment pattern and the FSM states
//   of the deserializer.
// -----------------------------------------------------------------------------
package lp_serdes_pkg;

   localparam int unsigned         LP_WIDTH     = 16;
   localparam logic [LP_WIDTH-1:0] LP_SYNC_WORD = 16'hF00F;

   typedef enum logic {
      HUNT = 1'b0,
      LOCK = 1'b1
   } lp_state_e;

endpackage

// File: rtl/lp_tree_deserializer_if.sv
// -----------------------------------------------------------------------------
// lp_tree_deserializer_if
//   Serial input and recovered-word outputs of lp_tree_deserializer.
//   master : stream source / result consumer (drives SERIAL_IN)
//   slave  : the deserializer (drives PAR_OUT, PAR_VALID, IS_SYNC, LOCKED,
//            LOCK_LOST)
// -----------------------------------------------------------------------------
interface lp_tree_deserializer_if
   import lp_serdes_pkg::*;
#(
   parameter int unsigned WIDTH = LP_WIDTH
);

   logic             SERIAL_IN;
   logic [WIDTH-1:0] PAR_OUT;
   logic             PAR_VALID;
   logic             IS_SYNC;
   logic             LOCKED;
   logic             LOCK_LOST;

   modport master (
      output SERIAL_IN,
      input  PAR_OUT, PAR_VALID, IS_SYNC, LOCKED, LOCK_LOST
   );

   modport slave (
      input  SERIAL_IN,
      output PAR_OUT, PAR_VALID, IS_SYNC, LOCKED, LOCK_LOST
   );

endinterface

// File: rtl/lp_sync_detect.sv
// -----------------------------------------------------------------------------
// lp_sync_detect
//   WIDTH-bit shift register (new bit enters at the LSB) plus a comparator of
//   the post-shift value against SYNC_WORD.
//   clk, rst  : clock, synchronous active-high reset
//   serial_in : incoming bit
//   shifted   : shift register contents including the current bit
//   match     : shifted == SYNC_WORD
// -----------------------------------------------------------------------------
module lp_sync_detect #(
   parameter int unsigned     WIDTH     = 16,
   parameter logic [WIDTH-1:0] SYNC_WORD = 16'hF00F
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             serial_in,
   output logic [WIDTH-1:0] shifted,
   output logic             match
);

   logic [WIDTH-1:0] sr_q;
   logic [WIDTH-1:0] sr_d;

   always_comb begin
      shifted = {sr_q[WIDTH-2:0], serial_in};
      sr_d    = shifted;
      match   = (shifted == SYNC_WORD);
   end

   // Reset has priority, so bits presented during reset never get in.
   always_ff @(posedge clk) begin
      if (rst) sr_q <= '0;
      else     sr_q <= sr_d;
   end

endmodule

// File: rtl/lp_tree_deserializer.sv
// -----------------------------------------------------------------------------
// lp_tree_deserializer
//   Recovers WIDTH-bit words from an MSB-first serial stream. HUNT searches
//   every bit position for SYNC_WORD; LOCK then slices words on the found
//   boundary and drops back to HUNT if more than MAX_GAP data words pass
//   without a sync word.
//   CLK, RESET : clock, synchronous active-high reset
//   bus        : SERIAL_IN in; PAR_OUT, PAR_VALID, IS_SYNC, LOCKED, LOCK_LOST out
// -----------------------------------------------------------------------------
module lp_tree_deserializer
   import lp_serdes_pkg::*;
#(
   parameter int unsigned      WIDTH     = LP_WIDTH,
   parameter logic [WIDTH-1:0] SYNC_WORD = LP_SYNC_WORD,
   parameter int unsigned      MAX_GAP   = 8
) (
   input  logic                   CLK,
   input  logic                   RESET,
   lp_tree_deserializer_if.slave  bus
);

   localparam int unsigned CNT_W = $clog2(WIDTH);
   localparam int unsigned GAP_W = $clog2(MAX_GAP + 2);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
   localparam logic [GAP_W-1:0] GAP_MAX  = GAP_W'(MAX_GAP);

   logic [WIDTH-1:0] shifted;
   logic             match;

   lp_sync_detect #(
      .WIDTH     (WIDTH),
      .SYNC_WORD (SYNC_WORD)
   ) u_sync_detect (
      .clk       (CLK),
      .rst       (RESET),
      .serial_in (bus.SERIAL_IN),
      .shifted   (shifted),
      .match     (match)
   );

   lp_state_e        state_q,     state_d;
   logic [CNT_W-1:0] bit_cnt_q,   bit_cnt_d;
   logic [GAP_W-1:0] gap_cnt_q,   gap_cnt_d;
   logic [WIDTH-1:0] par_out_q,   par_out_d;
   logic             par_valid_q, par_valid_d;
   logic             is_sync_q,   is_sync_d;
   logic             lock_lost_q, lock_lost_d;

   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      gap_cnt_d   = gap_cnt_q;
      par_out_d   = par_out_q;
      par_valid_d = 1'b0;
      is_sync_d   = 1'b0;
      lock_lost_d = 1'b0;

      case (state_q)
         HUNT: begin
            if (match) begin
               state_d   = LOCK;
               bit_cnt_d = '0;
               gap_cnt_d = '0;
            end
         end
         LOCK: begin
            if (bit_cnt_q == LAST_BIT) begin
               bit_cnt_d = '0;
               if (match) begin
                  gap_cnt_d   = '0;
                  par_out_d   = shifted;
                  par_valid_d = 1'b1;
                  is_sync_d   = 1'b1;
               end else if (gap_cnt_q == GAP_MAX) begin
                  // This word would push the gap past MAX_GAP: drop it and re-hunt.
                  state_d     = HUNT;
                  gap_cnt_d   = '0;
                  lock_lost_d = 1'b1;
               end else begin
                  gap_cnt_d   = gap_cnt_q + 1'b1;
                  par_out_d   = shifted;
                  par_valid_d = 1'b1;
               end
            end else begin
               bit_cnt_d = bit_cnt_q + 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q     <= HUNT;
         bit_cnt_q   <= '0;
         gap_cnt_q   <= '0;
         par_out_q   <= '0;
         par_valid_q <= 1'b0;
         is_sync_q   <= 1'b0;
         lock_lost_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         gap_cnt_q   <= gap_cnt_d;
         par_out_q   <= par_out_d;
         par_valid_q <= par_valid_d;
         is_sync_q   <= is_sync_d;
         lock_lost_q <= lock_lost_d;
      end
   end

   assign bus.PAR_OUT   = par_out_q;
   assign bus.PAR_VALID = par_valid_q;
   assign bus.IS_SYNC   = is_sync_q;
   assign bus.LOCKED    = (state_q == LOCK);
   assign bus.LOCK_LOST = lock_lost_q;

endmodule

// File: tb/tb_lp_tree_deserializer.sv
// -----------------------------------------------------------------------------
// tb_lp_tree_deserializer
//   Directed bench for lp_tree_deserializer. Expected words are queued as they
//   are serialized and popped when PAR_VALID is observed.
// -----------------------------------------------------------------------------
module tb_lp_tree_deserializer;
   import lp_serdes_pkg::*;

   localparam int unsigned W    = 16;
   localparam logic [W-1:0] SYNC = 16'hF00F;

   typedef struct packed {
      logic [W-1:0] word;
      logic         sync;
   } exp_t;

   logic CLK   = 1'b0;
   logic RESET = 1'b1;

   lp_tree_deserializer_if #(.WIDTH(W)) bus ();

   lp_tree_deserializer #(
      .WIDTH     (W),
      .SYNC_WORD (SYNC),
      .MAX_GAP   (8)
   ) dut (
      .CLK   (CLK),
      .RESET (RESET),
      .bus   (bus)
   );

   always #5 CLK = ~CLK;

   int   vectors     = 0;
   int   miscompares = 0;
   int   lost_seen   = 0;
   bit   mon_en      = 1'b0;
   exp_t sb[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Output monitor / scoreboard pop, away from the active edge.
   always @(negedge CLK) begin : mon
      exp_t e;
      if (mon_en) begin
         if (bus.LOCK_LOST === 1'b1) lost_seen++;
         if (bus.PAR_VALID === 1'b1) begin
            if (sb.size() == 0) begin
               chk("unexpected_par_valid", 32'(bus.PAR_OUT), 32'hFFFF_FFFF);
            end else begin
               e = sb.pop_front();
               chk("par_out", 32'(bus.PAR_OUT), 32'(e.word));
               chk("is_sync", 32'(bus.IS_SYNC), 32'(e.sync));
            end
         end else begin
            chk("is_sync_idle", 32'(bus.IS_SYNC), 32'd0);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
      $fatal(1);
   end

   task automatic send_bit(input logic b);
      bus.SERIAL_IN = b;
      @(posedge CLK);
      #1;
   endtask

   task automatic send_word(input logic [W-1:0] w, input bit expect_out);
      if (expect_out) sb.push_back('{word: w, sync: (w == SYNC)});
      for (int i = W - 1; i >= 0; i--) send_bit(w[i]);
   endtask

   task automatic do_reset();
      RESET = 1'b1;
      send_bit(1'b0);
      send_bit(1'b0);
      RESET = 1'b0;
   endtask

   task automatic chk_outputs_zero(input string tag);
      chk({tag, "_par_out"},   32'(bus.PAR_OUT),   32'd0);
      chk({tag, "_par_valid"}, 32'(bus.PAR_VALID), 32'd0);
      chk({tag, "_is_sync"},   32'(bus.IS_SYNC),   32'd0);
      chk({tag, "_locked"},    32'(bus.LOCKED),    32'd0);
      chk({tag, "_lock_lost"}, 32'(bus.LOCK_LOST), 32'd0);
   endtask

   initial begin
      logic [W-1:0] w;
      logic [W-1:0] chain_words[7];
      chain_words = '{16'hC5AF, 16'hFF00, 16'hF00F, 16'hCC33, 16'h8811, 16'hA815, 16'hA995};

      // Reset: feed the upper 12 sync bits while RESET is high; if they got in,
      // the 4 ones after release would complete a false match.
      bus.SERIAL_IN = 1'b0;
      RESET = 1'b1;
      @(posedge CLK);
      #1;
      mon_en = 1'b1;
      w = SYNC;
      for (int i = W - 1; i >= 4; i--) send_bit(w[i]);
      chk_outputs_zero("reset");
      RESET = 1'b0;
      for (int i = 3; i >= 0; i--) send_bit(w[i]);
      chk("reset_bits_ignored_locked", 32'(bus.LOCKED), 32'd0);

      // Two syncs then C5AF: two PAR_VALID pulses, data one 1 cycle after its last bit.
      do_reset();
      send_word(SYNC, 1'b0);
      chk("acq_locked", 32'(bus.LOCKED), 32'd1);
      chk("acq_no_valid", 32'(bus.PAR_VALID), 32'd0);
      send_word(SYNC, 1'b1);
      sb.push_back('{word: 16'hC5AF, sync: 1'b0});
      w = 16'hC5AF;
      for (int i = W - 1; i >= 1; i--) send_bit(w[i]);
      chk("c5af_valid_early", 32'(bus.PAR_VALID), 32'd0);
      send_bit(w[0]);
      chk("c5af_valid", 32'(bus.PAR_VALID), 32'd1);
      chk("c5af_par_out", 32'(bus.PAR_OUT), 32'hC5AF);
      chk("c5af_is_sync", 32'(bus.IS_SYNC), 32'd0);

      // Junk bits ahead of the sync: lock must follow the sync, not the junk.
      do_reset();
      for (int i = 0; i < 5; i++) send_bit(1'($urandom_range(0, 1)));
      chk("junk_not_locked", 32'(bus.LOCKED), 32'd0);
      send_word(SYNC, 1'b0);
      chk("junk_locked", 32'(bus.LOCKED), 32'd1);
      send_word(16'hFF00, 1'b1);
      chk("ff00_par_out", 32'(bus.PAR_OUT), 32'hFF00);

      // Gap overflow: 8 data words still accepted, the 9th drops lock.
      do_reset();
      send_word(SYNC, 1'b0);
      send_word(SYNC, 1'b1);
      for (int i = 0; i < 8; i++) send_word(16'h1230 + 16'(i), 1'b1);
      chk("gap8_still_locked", 32'(bus.LOCKED), 32'd1);
      send_word(16'h5A5A, 1'b0);
      chk("gap9_lock_lost", 32'(bus.LOCK_LOST), 32'd1);
      chk("gap9_locked", 32'(bus.LOCKED), 32'd0);
      chk("gap9_no_valid", 32'(bus.PAR_VALID), 32'd0);
      send_bit(1'b0);
      chk("gap9_lock_lost_pulse", 32'(bus.LOCK_LOST), 32'd0);

      // 0F00 followed by F0A5 puts F00F across the word boundary.
      do_reset();
      send_word(SYNC, 1'b0);
      send_word(SYNC, 1'b1);
      send_word(16'h0F00, 1'b1);
      send_word(16'hF0A5, 1'b1);
      chk("straddle_locked", 32'(bus.LOCKED), 32'd1);
      chk("straddle_par_out", 32'(bus.PAR_OUT), 32'hF0A5);
      send_word(SYNC, 1'b1);

      // Reset mid-word while locked: partial word discarded, no LOCK_LOST.
      do_reset();
      send_word(SYNC, 1'b0);
      send_word(SYNC, 1'b1);
      w = 16'h1234;
      for (int i = W - 1; i >= 9; i--) send_bit(w[i]);
      RESET = 1'b1;
      send_bit(w[8]);
      chk_outputs_zero("midword_reset");
      send_bit(w[7]);
      RESET = 1'b0;
      send_word(SYNC, 1'b0);
      chk("relock_locked", 32'(bus.LOCKED), 32'd1);
      send_word(16'h3C3C, 1'b1);
      chk("relock_par_out", 32'(bus.PAR_OUT), 32'h3C3C);

      // Serializer chain: frame starts with a sync, then a sync before every third word.
      do_reset();
      send_word(SYNC, 1'b0);
      for (int k = 0; k < 7; k++) begin
         if (k % 3 == 0) send_word(SYNC, 1'b1);
         send_word(chain_words[k], 1'b1);
      end
      send_word(SYNC, 1'b1);
      for (int i = 0; i < 4; i++) send_bit(1'b0);

      chk("sb_drained", 32'(sb.size()), 32'd0);
      chk("lock_lost_count", 32'(lost_seen), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
